// File: rtl/parity_serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first,
// selectable odd/even parity bit, stop bit. Each bit lasts CLKS_PER_BIT
// clocks. A word is taken through a valid/ready handshake in IDLE only.
module parity_serial_tx #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              parity_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cntNext;
   logic [IW-1:0]     r_bitIdx;
   logic [IW-1:0]     w_bitIdxNext;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shiftNext;
   logic              r_parity;
   logic              w_parityNext;
   logic              r_tx;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;
   logic              w_txNext;
   logic              w_readyNext;
   logic              w_doneNext;
   logic              w_bitEnd;
   logic              w_accept;

   assign w_bitEnd = (r_cnt == CNT_LAST);
   assign w_accept = (r_state == IDLE) && in_valid && r_ready;

   // State register; reset aborts any frame and returns to IDLE at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state decision: each non-idle state ends on the last cycle of its bit
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_stateNext = START;
         START:   if (w_bitEnd) w_stateNext = DATA;
         DATA:    if (w_bitEnd && (r_bitIdx == IDX_LAST)) w_stateNext = PARITY;
         PARITY:  if (w_bitEnd) w_stateNext = STOP;
         STOP:    if (w_bitEnd) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Next values of counters, shift register and latched parity bit
   always_comb begin
      w_cntNext    = r_cnt;
      w_bitIdxNext = r_bitIdx;
      w_shiftNext  = r_shift;
      w_parityNext = r_parity;
      if (w_stateNext != r_state) begin
         w_cntNext    = '0;
         w_bitIdxNext = '0;
      end else if ((r_state == DATA) && w_bitEnd) begin
         w_cntNext    = '0;
         w_bitIdxNext = r_bitIdx + 1'b1;
      end else if (r_state != IDLE) begin
         w_cntNext = r_cnt + 1'b1;
      end
      if (w_accept) begin
         w_shiftNext  = data_in;
         w_parityNext = parity_sel ? (^data_in) : ~(^data_in);
      end else if ((r_state == DATA) && w_bitEnd) begin
         w_shiftNext = r_shift >> 1;
      end
   end

   // Output decode from the upcoming state so every output can be registered
   always_comb begin
      w_txNext    = 1'b1;
      w_readyNext = (w_stateNext == IDLE);
      w_doneNext  = (w_stateNext == STOP) && (w_cntNext == CNT_LAST);
      case (w_stateNext)
         START:   w_txNext = 1'b0;
         DATA:    w_txNext = w_shiftNext[0];
         PARITY:  w_txNext = w_parityNext;
         default: w_txNext = 1'b1;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_cnt    <= w_cntNext;
         r_bitIdx <= w_bitIdxNext;
         r_shift  <= w_shiftNext;
         r_parity <= w_parityNext;
         r_tx     <= w_txNext;
         r_ready  <= w_readyNext;
         r_busy   <= ~w_readyNext;
         r_done   <= w_doneNext;
      end
   end

   assign tx_out     = r_tx;
   assign in_ready   = r_ready;
   assign busy       = r_busy;
   assign frame_done = r_done;

endmodule
